// File: rtl/tree_pkg.sv
// Shared definitions for the decision-tree walker: node word layout,
// leaf marker, walker FSM states and child-address extraction.
package tree_pkg;

    localparam int NODE_W    = 120;
    localparam int CLASS_LSB = 0;
    localparam int CLASS_W   = 4;
    localparam int RIGHT_LSB = 4;
    localparam int LEFT_LSB  = 16;
    localparam int CHILD_W   = 12;
    localparam int THR_LSB   = 28;
    localparam int THR_W     = 64;
    localparam int CODE_LSB  = 92;
    localparam int CODE_W    = 4;
    localparam int ID_LSB    = 96;
    localparam int ID_W      = 12;

    localparam logic [CODE_W-1:0] LEAF_CODE = 4'h3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EVAL,
        DONE
    } walk_state_t;

    // Full-width child field selected by the comparison outcome; the caller
    // truncates it to the ROM address width.
    function automatic logic [CHILD_W-1:0] node_child(input logic [NODE_W-1:0] node,
                                                      input logic go_left);
        return go_left ? node[LEFT_LSB +: CHILD_W] : node[RIGHT_LSB +: CHILD_W];
    endfunction

endpackage

// File: rtl/fp64_le.sv
// Combinational a <= b for IEEE-754 doubles using the sign-magnitude to
// ordered-key mapping; both zeros compare equal, NaNs follow the bit order.
module fp64_le (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        le
);

    logic [63:0] key_a;
    logic [63:0] key_b;
    logic        both_zero;

    // Map each operand to an unsigned key whose order matches the double order.
    always_comb begin
        key_a     = a[63] ? ~a : {1'b1, a[62:0]};
        key_b     = b[63] ? ~b : {1'b1, b[62:0]};
        both_zero = (a[62:0] == 63'd0) && (b[62:0] == 63'd0);
        le        = both_zero || (key_a <= key_b);
    end

endmodule

// File: rtl/tree_walker.sv
// Walks a decision tree held in a registered ROM from the root to a leaf,
// comparing one latched feature per internal node, and hands the leaf class
// downstream over a valid/ready handshake.
module tree_walker
    import tree_pkg::*;
#(
    parameter int NODE_WIDTH = 120,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_FEAT   = 16,
    parameter int MAX_DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_FEAT*64-1:0]   features,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    input  logic [NODE_WIDTH-1:0]    rom_data,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [3:0]               res_class,
    output logic                     res_err,
    output logic [5:0]               depth
);

    walk_state_t             state;
    walk_state_t             state_next;
    logic [NUM_FEAT*64-1:0]  feat_q;
    logic [NUM_FEAT*64-1:0]  feat_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    busy_next;
    logic                    valid_next;
    logic [3:0]              class_next;
    logic                    err_next;
    logic [5:0]              depth_next;

    logic [CODE_W-1:0]       code;
    logic [THR_W-1:0]        thr;
    logic [63:0]             sel_feat;
    logic                    go_left;
    logic                    unused_node_bits;

    assign code             = rom_data[CODE_LSB +: CODE_W];
    assign thr              = rom_data[THR_LSB +: THR_W];
    assign unused_node_bits = ^rom_data[NODE_WIDTH-1:ID_LSB];

    // Pick the feature named by the node; out-of-range codes fall back to feature 0.
    always_comb begin
        sel_feat = feat_q[63:0];
        for (int i = 0; i < NUM_FEAT; i++) begin
            if (int'(code) == i) begin
                sel_feat = feat_q[64*i +: 64];
            end
        end
    end

    fp64_le u_cmp (
        .a  (sel_feat),
        .b  (thr),
        .le (go_left)
    );

    // State and datapath registers; reset aborts any walk without a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            feat_q    <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_class <= 4'd0;
            res_err   <= 1'b0;
            depth     <= 6'd0;
        end else begin
            state     <= state_next;
            feat_q    <= feat_next;
            rom_addr  <= addr_next;
            busy      <= busy_next;
            res_valid <= valid_next;
            res_class <= class_next;
            res_err   <= err_next;
            depth     <= depth_next;
        end
    end

    // Next-state logic: fetch/evaluate alternate per node until a leaf or the depth limit.
    always_comb begin
        state_next = state;
        feat_next  = feat_q;
        addr_next  = rom_addr;
        busy_next  = busy;
        valid_next = res_valid;
        class_next = res_class;
        err_next   = res_err;
        depth_next = depth;
        case (state)
            IDLE: begin
                if (start) begin
                    feat_next  = features;
                    addr_next  = '0;
                    depth_next = 6'd0;
                    busy_next  = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = EVAL;
            end
            EVAL: begin
                if (code == LEAF_CODE) begin
                    class_next = rom_data[CLASS_LSB +: CLASS_W];
                    err_next   = 1'b0;
                    valid_next = 1'b1;
                    state_next = DONE;
                end else if (depth == 6'(MAX_DEPTH)) begin
                    class_next = 4'd0;
                    err_next   = 1'b1;
                    valid_next = 1'b1;
                    state_next = DONE;
                end else begin
                    addr_next  = ADDR_WIDTH'(node_child(rom_data, go_left));
                    depth_next = depth + 6'd1;
                    state_next = FETCH;
                end
            end
            DONE: begin
                if (res_ready) begin
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tree_walker.sv
// Self-checking bench for tree_walker: a behavioural ROM, a real-valued
// reference walk, a per-cycle compare process, directed cases and random traffic.
module tb_tree_walker;

    localparam int NODE_WIDTH = 120;
    localparam int ADDR_WIDTH = 10;
    localparam int NUM_FEAT   = 16;
    localparam int MAX_DEPTH  = 32;

    localparam logic [63:0] D_POS0 = 64'h0000_0000_0000_0000;
    localparam logic [63:0] D_NEG0 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] D_1    = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D_M1   = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] D_2    = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D_M2   = 64'hC000_0000_0000_0000;
    localparam logic [63:0] D_100  = 64'h4059_0000_0000_0000;
    localparam logic [63:0] D_200  = 64'h4069_0000_0000_0000;
    localparam logic [63:0] D_1925 = 64'h4068_1000_0000_0000;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    res_ready = 1'b0;
    logic [NUM_FEAT*64-1:0]  features = '0;
    logic [ADDR_WIDTH-1:0]   rom_addr;
    logic [NODE_WIDTH-1:0]   rom_data;
    logic                    busy;
    logic                    res_valid;
    logic [3:0]              res_class;
    logic                    res_err;
    logic [5:0]              depth;

    logic [NODE_WIDTH-1:0]   mem [0:1023];

    logic [63:0]             ua = '0;
    logic [63:0]             ub = '0;
    logic                    ule;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int               m_path [0:63];
    int               m_n = 1;
    logic [3:0]       m_class = 4'd0;
    logic             m_err = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_valid = 1'b0;
    logic [9:0]       m_addr = '0;
    int               m_depth = 0;
    int               m_k = 0;
    int               m_idx;

    always #5 clk = ~clk;

    tree_walker #(
        .NODE_WIDTH (NODE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_FEAT   (NUM_FEAT),
        .MAX_DEPTH  (MAX_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .features  (features),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_err   (res_err),
        .depth     (depth)
    );

    fp64_le u_le (
        .a  (ua),
        .b  (ub),
        .le (ule)
    );

    // Registered tree ROM: data for an address appears one clock later.
    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NODE_WIDTH-1:0] make_node(input logic [3:0] code, input logic [63:0] thr,
                                                        input logic [11:0] left, input logic [11:0] right,
                                                        input logic [3:0] cls);
        logic [NODE_WIDTH-1:0] n;
        n          = '0;
        n[3:0]     = cls;
        n[15:4]    = right;
        n[27:16]   = left;
        n[91:28]   = thr;
        n[95:92]   = code;
        n[107:96]  = 12'($urandom_range(0, 4095));
        return n;
    endfunction

    function automatic logic [63:0] rand_double();
        logic [63:0] r;
        case ($urandom_range(0, 9))
            0: r = D_POS0;
            1: r = D_NEG0;
            2: r = D_1;
            3: r = D_M1;
            4: r = D_2;
            5: r = D_M2;
            6: r = D_1925;
            default: begin
                r = {$urandom, $urandom};
                if (r[62:52] == 11'h7FF) r[62] = 1'b0;
            end
        endcase
        return r;
    endfunction

    // Reference walk using real-number comparison on the current ROM image.
    function automatic void walk(input logic [NUM_FEAT*64-1:0] fv);
        int a;
        int fi;
        logic [NODE_WIDTH-1:0] nd;
        real f;
        real t;
        a = 0;
        for (int d = 0; d <= MAX_DEPTH; d++) begin
            nd        = mem[a];
            m_path[d] = a;
            if (nd[95:92] == 4'h3) begin
                m_class = nd[3:0];
                m_err   = 1'b0;
                m_n     = d + 1;
                return;
            end
            if (d == MAX_DEPTH) begin
                m_class = 4'd0;
                m_err   = 1'b1;
                m_n     = d + 1;
                return;
            end
            fi = (int'(nd[95:92]) < NUM_FEAT) ? int'(nd[95:92]) : 0;
            f  = $bitstoreal(fv[64*fi +: 64]);
            t  = $bitstoreal(nd[91:28]);
            a  = (f <= t) ? (int'(nd[27:16]) % 1024) : (int'(nd[15:4]) % 1024);
        end
    endfunction

    // Cycle-level expectation: two cycles per visited node, then hold until accepted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_depth <= 0;
            m_k     <= 0;
        end else if (!m_busy) begin
            if (start) begin
                walk(features);
                m_busy  <= 1'b1;
                m_k     <= 1;
                m_addr  <= '0;
                m_depth <= 0;
            end
        end else if (m_valid) begin
            if (res_ready) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end
        end else begin
            m_idx = m_k / 2;
            if (m_idx > m_n - 1) m_idx = m_n - 1;
            m_k     <= m_k + 1;
            m_addr  <= 10'(m_path[m_idx]);
            m_depth <= m_idx;
            if (m_k + 1 == 2 * m_n + 1) m_valid <= 1'b1;
        end
    end

    // Compare DUT outputs against the model every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_busy);
            check("res_valid", res_valid, m_valid);
            check("rom_addr", rom_addr, m_addr);
            check("depth", depth, m_depth);
            if (m_valid) begin
                check("res_class", res_class, m_class);
                check("res_err", res_err, m_err);
            end
        end
    end

    task automatic run_one(input logic [NUM_FEAT*64-1:0] fv, input string name,
                           input int e_class, input int e_err, input int e_depth,
                           input int e_lat, input int e_addr);
        int lat;
        bit seen;
        features  = fv;
        start     = 1'b1;
        res_ready = 1'b1;
        lat       = 0;
        seen      = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (res_valid) seen = 1'b1;
        end
        check({name, " valid seen"}, seen, 1);
        check({name, " latency"}, lat, e_lat);
        check({name, " class"}, res_class, e_class);
        check({name, " err"}, res_err, e_err);
        check({name, " depth"}, depth, e_depth);
        check({name, " rom_addr"}, rom_addr, e_addr);
        tick();
        check({name, " busy after handshake"}, busy, 0);
    endtask

    task automatic random_tree();
        logic [3:0] code;
        logic [11:0] l;
        logic [11:0] r;
        for (int a = 0; a < 16; a++) begin
            code = ($urandom_range(0, 2) == 0) ? 4'h3 : 4'($urandom_range(0, 15));
            l    = 12'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 12'hC00 : 12'h000);
            r    = 12'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 12'h400 : 12'h000);
            mem[a] = make_node(code, rand_double(), l, r, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NUM_FEAT*64-1:0] fv;
        int w;

        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Comparator unit checks: pinned literals, then random pairs vs real compare
        ua = D_NEG0; ub = D_POS0; #1; check("le -0 <= +0", ule, 1);
        ua = D_POS0; ub = D_NEG0; #1; check("le +0 <= -0", ule, 1);
        ua = D_M1;   ub = D_M2;   #1; check("le -1 <= -2", ule, 0);
        ua = D_M2;   ub = D_M1;   #1; check("le -2 <= -1", ule, 1);
        ua = D_1925; ub = D_1925; #1; check("le equal", ule, 1);
        ua = D_200;  ub = D_1925; #1; check("le 200 <= 192.5", ule, 0);
        for (int i = 0; i < 40; i++) begin
            ua = rand_double();
            ub = rand_double();
            #1;
            check("le random", ule, ($bitstoreal(ua) <= $bitstoreal(ub)) ? 1 : 0);
        end

        // Reset values while rst_n is held low
        check("reset rom_addr", rom_addr, 0);
        check("reset busy", busy, 0);
        check("reset res_valid", res_valid, 0);
        check("reset res_class", res_class, 0);
        check("reset res_err", res_err, 0);
        check("reset depth", depth, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Root is a leaf
        mem[0] = make_node(4'h3, D_POS0, 12'd0, 12'd0, 4'd1);
        run_one('0, "leaf root", 1, 0, 0, 3, 0);

        // One decision on feature 1 against 192.5
        mem[0] = make_node(4'd1, D_1925, 12'd1, 12'd2, 4'd0);
        mem[1] = make_node(4'h3, D_POS0, 12'd0, 12'd0, 4'd1);
        mem[2] = make_node(4'h3, D_POS0, 12'd0, 12'd0, 4'd2);
        fv = '0; fv[64*1 +: 64] = D_100;
        run_one(fv, "f1=100 left", 1, 0, 1, 5, 1);
        fv = '0; fv[64*1 +: 64] = D_200;
        run_one(fv, "f1=200 right", 2, 0, 1, 5, 2);
        fv = '0; fv[64*1 +: 64] = D_1925;
        run_one(fv, "f1=t left", 1, 0, 1, 5, 1);

        // Signed-zero tie and negative ordering on feature 5
        mem[0] = make_node(4'd5, D_POS0, 12'd1, 12'd2, 4'd0);
        fv = '0; fv[64*5 +: 64] = D_NEG0;
        run_one(fv, "-0 vs +0 left", 1, 0, 1, 5, 1);
        mem[0] = make_node(4'd5, D_M2, 12'd1, 12'd2, 4'd0);
        fv = '0; fv[64*5 +: 64] = D_M1;
        run_one(fv, "-1 vs -2 right", 2, 0, 1, 5, 2);

        // Self-loop root hits the depth limit
        mem[0] = make_node(4'd0, D_POS0, 12'd0, 12'd0, 4'd9);
        run_one('0, "self loop", 0, 1, 32, 67, 0);

        // Backpressure: result held, second start ignored, restart after handshake
        mem[0] = make_node(4'd1, D_1925, 12'd1, 12'd2, 4'd0);
        fv = '0; fv[64*1 +: 64] = D_200;
        features  = fv;
        start     = 1'b1;
        res_ready = 1'b0;
        w = 0;
        while (!res_valid && w < 50) begin
            tick();
            start = 1'b0;
            w++;
        end
        check("bp valid seen", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp hold valid", res_valid, 1);
            check("bp hold busy", busy, 1);
            check("bp hold class", res_class, 2);
            check("bp hold depth", depth, 1);
            if (i == 1) begin
                start = 1'b1;
                features[64*1 +: 64] = D_100;
            end
            tick();
            start = 1'b0;
        end
        res_ready = 1'b1;
        start     = 1'b1;
        tick();
        check("bp busy falls", busy, 0);
        check("bp valid falls", res_valid, 0);
        tick();
        start = 1'b0;
        check("bp restart accepted", busy, 1);
        w = 0;
        while (busy && w < 50) begin
            tick();
            w++;
        end
        check("bp restart completes", busy, 0);

        // Four-level walk aborted by reset, then rerun cleanly
        for (int i = 0; i < 4; i++) mem[i] = make_node(4'd0, D_POS0, 12'd9, 12'(i + 1), 4'd0);
        mem[4] = make_node(4'h3, D_POS0, 12'd0, 12'd0, 4'd7);
        mem[9] = make_node(4'h3, D_POS0, 12'd0, 12'd0, 4'd5);
        fv = '0; fv[63:0] = D_1;
        features = fv;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort rom_addr", rom_addr, 0);
        check("abort busy", busy, 0);
        check("abort res_valid", res_valid, 0);
        check("abort res_class", res_class, 0);
        check("abort res_err", res_err, 0);
        check("abort depth", depth, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post-reset idle", busy, 0);
        run_one(fv, "chain after reset", 7, 0, 4, 11, 4);

        // Random trees, features, starts and backpressure
        random_tree();
        for (int n = 0; n < 2500; n++) begin
            if (!busy && $urandom_range(0, 39) == 0) random_tree();
            start     = ($urandom_range(0, 2) == 0);
            res_ready = $urandom_range(0, 1) == 1;
            for (int i = 0; i < NUM_FEAT; i++) features[64*i +: 64] = rand_double();
            tick();
        end
        start     = 1'b0;
        res_ready = 1'b1;
        w = 0;
        while (busy && w < 200) begin
            tick();
            w++;
        end
        check("random drain idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
